// File: rtl/fir_feeder_pkg.sv
// Shared types and constants for the FIR sample feeder.
// Coefficient count and datapath width are fixed by the filter it serves.
package fir_feeder_pkg;

  localparam int DW         = 16;
  localparam int NUM_COEFFS = 4;
  localparam int IDX_W      = $clog2(NUM_COEFFS);

  typedef enum logic [2:0] {
    IDLE,
    C_ASSERT,
    C_WAIT,
    S_ASSERT,
    S_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample queue for the FIR feeder.
// A push while full is accepted only when a pop happens in the same cycle.
module sample_fifo
  import fir_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_data  = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds coefficients and samples to a 4-tap FIR over a modwait handshake.
// Define FIR_FEEDER_TIMEOUT_EN to build the per-phase handshake timeout.
module fir_sample_feeder
  import fir_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [1:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic          reload,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          full,
  output logic          coeffs_valid,
  output logic [DW-1:0] sample_data,
  output logic [DW-1:0] fir_coefficient,
  output logic          data_ready,
  output logic          load_coeff,
  input  logic          modwait,
  input  logic [DW-1:0] fir_out,
  input  logic          err,
  output logic          result_valid,
  output logic [DW-1:0] result_data,
  output logic          result_err,
  output logic          timeout_err
);

  state_t           r_state;
  state_t           w_nraw;
  state_t           w_next;
  logic [DW-1:0]    r_coef [NUM_COEFFS];
  logic [IDX_W-1:0] r_idx;
  logic             r_pend;
  logic             r_cv;
  logic             r_rv;
  logic             r_rerr;
  logic [DW-1:0]    r_sample;
  logic [DW-1:0]    r_res;
  logic             w_rl;
  logic             w_pop;
  logic             w_acc;
  logic             w_inc;
  logic             w_cdone;
  logic             w_cap;
  logic             w_tmo;
  logic             w_sto;
  logic             w_empty;
  logic [DW-1:0]    w_fifo_data;

  sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (push),
    .i_pop  (w_pop),
    .i_data (push_data),
    .o_data (w_fifo_data),
    .o_full (full),
    .o_empty(w_empty)
  );

  assign w_rl = r_pend | reload;

  always_comb begin
    w_nraw  = r_state;
    w_pop   = 1'b0;
    w_acc   = 1'b0;
    w_inc   = 1'b0;
    w_cdone = 1'b0;
    w_cap   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rl) begin
          w_acc  = 1'b1;
          w_nraw = C_ASSERT;
        end else if (r_cv && !w_empty) begin
          w_pop  = 1'b1;
          w_nraw = S_ASSERT;
        end
      end
      C_ASSERT: if (modwait) w_nraw = C_WAIT;
      C_WAIT: begin
        if (!modwait) begin
          if (r_idx == IDX_W'(NUM_COEFFS - 1)) begin
            w_cdone = 1'b1;
            w_nraw  = IDLE;
          end else begin
            w_inc  = 1'b1;
            w_nraw = C_ASSERT;
          end
        end
      end
      S_ASSERT: if (modwait) w_nraw = S_WAIT;
      S_WAIT: begin
        if (!modwait) begin
          w_cap  = 1'b1;
          w_nraw = DONE;
        end
      end
      DONE:    w_nraw = IDLE;
      default: w_nraw = IDLE;
    endcase
  end

  assign w_next = w_tmo ? IDLE : w_nraw;

`ifdef FIR_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_terr;
  logic          w_hs;

  assign w_hs = (r_state == C_ASSERT) | (r_state == C_WAIT) |
                (r_state == S_ASSERT) | (r_state == S_WAIT);
  // Only a phase that is not completing this cycle can time out.
  assign w_tmo = w_hs & (w_nraw == r_state) &
                 (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_terr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      if (w_acc)      r_terr <= 1'b0;
      else if (w_tmo) r_terr <= 1'b1;
    end
  end
`else
  logic w_unused_tmo;

  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo        = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  assign w_sto = w_tmo & ((r_state == S_ASSERT) | (r_state == S_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEFFS; i++) r_coef[i] <= '0;
    end else if (cfg_wr) begin
      r_coef[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_cv     <= 1'b0;
      r_rv     <= 1'b0;
      r_rerr   <= 1'b0;
      r_sample <= '0;
      r_res    <= '0;
    end else begin
      r_state <= w_next;
      r_rv    <= (w_next == DONE) | w_sto;
      if (w_acc) begin
        r_idx  <= '0;
        r_cv   <= 1'b0;
        r_pend <= 1'b0;
      end else begin
        r_pend <= r_pend | reload;
        if (w_inc)   r_idx <= r_idx + 1'b1;
        if (w_cdone) r_cv  <= 1'b1;
      end
      if (w_pop) r_sample <= w_fifo_data;
      if (w_cap) begin
        r_res  <= fir_out;
        r_rerr <= err;
      end else if (w_sto) begin
        r_res  <= '0;
        r_rerr <= 1'b1;
      end
    end
  end

  assign load_coeff      = (r_state == C_ASSERT);
  assign data_ready      = (r_state == S_ASSERT);
  assign fir_coefficient = (load_coeff | (r_state == C_WAIT)) ?
                           r_coef[r_idx] : '0;
  assign sample_data     = r_sample;
  assign coeffs_valid    = r_cv;
  assign result_valid    = r_rv;
  assign result_data     = r_res;
  assign result_err      = r_rerr;

endmodule
